prio_arbiter_rr: RTL

//  Parametrised, registered successor to the 4-bit combinational priority encoder.

---
 rtl/prio_arbiter_rr.sv | 110 +++++++++++
 1 files changed

// File: rtl/prio_arbiter_rr.sv
// Registered N-way request arbiter with run-time fixed-priority / round-robin selection.
// The grant is held under a valid/ready handshake until the consumer accepts it.
module prio_arbiter_rr #(
    parameter int unsigned N = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot
);

    logic             grant_valid_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [N-1:0]     grant_onehot_q;
    logic [IDX_W-1:0] ptr_q;

    logic             accept;
    logic             arb_en;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] ptr_eff;
    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic             rr_found;
    int unsigned      rr_off;
    int unsigned      rr_sum;

    assign accept = grant_valid_q & grant_ready;
    assign arb_en = ~grant_valid_q | grant_ready;

    always_comb begin
        next_idx = grant_idx_q + 1'b1;
        if (32'(grant_idx_q) == N - 1) begin
            next_idx = '0;
        end
        // The just-served requester drops to lowest priority in the same cycle it is accepted.
        ptr_eff = accept ? next_idx : ptr_q;
    end

    // Fixed priority: highest set index wins.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = IDX_W'(i);
            end
        end
    end

    // Round robin: rotate so ptr_eff lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req} >> ptr_eff;
        req_rot  = req_dbl[N-1:0];
        rr_found = 1'b0;
        rr_off   = 0;
        for (int i = 0; i < N; i++) begin
            if (req_rot[i] && !rr_found) begin
                rr_found = 1'b1;
                rr_off   = i;
            end
        end
        rr_sum = 32'(ptr_eff) + rr_off;
        if (rr_sum >= N) begin
            rr_sum = rr_sum - N;
        end
        rr_idx = IDX_W'(rr_sum);
    end

    always_comb begin
        win_idx    = mode ? rr_idx : fix_idx;
        win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            ptr_q          <= '0;
        end else begin
            if (arb_en) begin
                if (|req) begin
                    grant_valid_q  <= 1'b1;
                    grant_idx_q    <= win_idx;
                    grant_onehot_q <= win_onehot;
                end else begin
                    grant_valid_q  <= 1'b0;
                    grant_idx_q    <= '0;
                    grant_onehot_q <= '0;
                end
            end
            if (accept && mode) begin
                ptr_q <= next_idx;
            end
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;

endmodule
